// File: rtl/trace_pkg.sv
// Shared types for the retirement trace monitor: record layout, kinds and FSM states.
package trace_pkg;

    localparam int TR_XLEN  = 32;
    localparam int TR_CNT_W = 32;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        STORE = 2'd1,
        BR_T  = 2'd2,
        BR_NT = 2'd3
    } trace_kind_e;

    typedef struct packed {
        logic [TR_CNT_W-1:0] cycle;
        logic [1:0]          chan;
        trace_kind_e         kind;
        logic [TR_XLEN-1:0]  tag;
        logic [31:0]         instr;
        logic [TR_XLEN-1:0]  addr;
        logic [TR_XLEN-1:0]  data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // Number of set bits in a channel strobe vector (channels never exceed 4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/trace_fifo_mw.sv
// Multi-write / single-read FIFO. Valid push lanes are packed into consecutive
// slots in ascending lane order; the caller guarantees there is room.
module trace_fifo_mw #(
    parameter int W     = 8,
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         push,
    input  logic [NCH-1:0][W-1:0]  push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic [AW:0]            count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] slot [NCH];
    logic [AW:0]   n_push;
    logic          pop_fire;

    assign empty    = (count == '0);
    assign pop_fire = pop && !empty;
    assign head     = mem[rd_ptr];

    // Each valid lane lands at write pointer + number of valid lanes below it.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NCH; i++) begin
            slot[i] = wr_ptr + n_push[AW-1:0];
            n_push  = n_push + (AW+1)'(push[i]);
        end
    end

    // Storage array, written only into free slots so the head never moves under a reader.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) mem[slot[i]] <= push_data[i];
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy carries one extra bit for full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            rd_ptr <= rd_ptr + AW'(pop_fire);
            count  <= count + n_push - (AW+1)'(pop_fire);
        end
    end

endmodule

// File: rtl/retire_trace_monitor.sv
// Retirement trace monitor: stamps retire events into a trace FIFO, detects the
// finish store and a no-retire watchdog, then drains the FIFO before reporting done.
//
// Trace stream handshake: trace_valid is high whenever the FIFO holds a record;
// a record is consumed on a clock edge where trace_valid & trace_ready; while
// trace_valid & !trace_ready the head record holds steady.
module retire_trace_monitor
    import trace_pkg::*;
#(
    parameter int               XLEN           = TR_XLEN,
    parameter int               NCH            = 2,
    parameter int               DEPTH          = 16,
    parameter int               CNT_W          = TR_CNT_W,
    parameter int               TIMEOUT_CYCLES = 1000,
    parameter logic [XLEN-1:0]  FINISH_ADDR    = 'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NCH-1:0]        ret_valid,
    input  logic [NCH*2-1:0]      ret_kind,
    input  logic [NCH*XLEN-1:0]   ret_tag,
    input  logic [NCH*32-1:0]     ret_instr,
    input  logic [NCH*XLEN-1:0]   ret_addr,
    input  logic [NCH*XLEN-1:0]   ret_data,
    input  logic                  fin_wen,
    input  logic [XLEN-1:0]       fin_waddr,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output trace_rec_t            trace_rec,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  done,
    output mon_state_e            dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $bits(trace_rec_t);

    mon_state_e              state;
    logic [CNT_W-1:0]        idle_cnt;
    logic [AW:0]             fifo_count;
    logic                    fifo_empty;
    logic [NCH-1:0]          push;
    trace_rec_t [NCH-1:0]    recs;
    logic [RW-1:0]           fifo_head;
    logic [2:0]              n_valid;
    logic                    in_run;
    logic                    fits;
    logic                    fin_hit;
    logic                    to_hit;
    logic [CNT_W:0]          drop_sum;

    assign n_valid     = popcount4(4'(ret_valid));
    assign in_run      = (state == RUN);
    // Room is judged on occupancy before this cycle's pop; a cycle is admitted whole or not at all.
    assign fits        = (int'(n_valid) <= (DEPTH - int'(fifo_count)));
    assign push        = (in_run && fits) ? ret_valid : '0;
    assign fin_hit     = fin_wen && (fin_waddr == FINISH_ADDR);
    assign to_hit      = (n_valid == 3'd0) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop_sum    = {1'b0, drop_count} + (CNT_W+1)'(n_valid);
    assign trace_valid = !fifo_empty;
    assign trace_rec   = fifo_head;
    assign dbg_state   = state;

    // Build one candidate record per channel, stamped with the current cycle count.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            recs[i].cycle = TR_CNT_W'(cycle_count);
            recs[i].chan  = 2'(i);
            recs[i].kind  = trace_kind_e'(ret_kind[2*i +: 2]);
            recs[i].tag   = TR_XLEN'(ret_tag[XLEN*i +: XLEN]);
            recs[i].instr = ret_instr[32*i +: 32];
            recs[i].addr  = TR_XLEN'(ret_addr[XLEN*i +: XLEN]);
            recs[i].data  = TR_XLEN'(ret_data[XLEN*i +: XLEN]);
        end
    end

    trace_fifo_mw #(
        .W     (RW),
        .NCH   (NCH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (recs),
        .pop       (trace_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Run-control FSM; finish takes priority over the watchdog in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timeout <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (en) state <= RUN;
                RUN: begin
                    if (fin_hit) begin
                        state <= DRAIN;
                    end else if (to_hit) begin
                        state   <= DRAIN;
                        timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating cycle, idle and drop counters plus the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            idle_cnt    <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if ((state == RUN || state == DRAIN) && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
            if (in_run) begin
                if (n_valid != 3'd0)      idle_cnt <= '0;
                else if (idle_cnt != '1)  idle_cnt <= idle_cnt + 1'b1;
                if (!fits) begin
                    drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
                    overflow   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Self-checking bench for retire_trace_monitor: scoreboard of expected trace
// records plus direct checks of FSM state, counters and sticky flags.
module tb_retire_trace_monitor;
    import trace_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          NCH   = 2;
    localparam int          DEPTH = 16;
    localparam int          CNT_W = 32;
    localparam int          TMO   = 10;
    localparam logic [31:0] FIN   = 32'h1000_0000;
    localparam int          REC_W = $bits(trace_rec_t);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [NCH-1:0]       ret_valid;
    logic [NCH*2-1:0]     ret_kind;
    logic [NCH*XLEN-1:0]  ret_tag;
    logic [NCH*32-1:0]    ret_instr;
    logic [NCH*XLEN-1:0]  ret_addr;
    logic [NCH*XLEN-1:0]  ret_data;
    logic                 fin_wen;
    logic [XLEN-1:0]      fin_waddr;
    logic                 trace_valid;
    logic                 trace_ready;
    trace_rec_t           trace_rec;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     drop_count;
    logic                 overflow;
    logic                 timeout;
    logic                 done;
    mon_state_e           dbg_state;

    logic [REC_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    retire_trace_monitor #(
        .XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TMO), .FINISH_ADDR(FIN)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .ret_valid(ret_valid), .ret_kind(ret_kind), .ret_tag(ret_tag),
        .ret_instr(ret_instr), .ret_addr(ret_addr), .ret_data(ret_data),
        .fin_wen(fin_wen), .fin_waddr(fin_waddr),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_rec(trace_rec),
        .cycle_count(cycle_count), .drop_count(drop_count),
        .overflow(overflow), .timeout(timeout), .done(done), .dbg_state(dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench hung");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_in();
        ret_valid = '0;
        ret_kind  = '0;
        ret_tag   = '0;
        ret_instr = '0;
        ret_addr  = '0;
        ret_data  = '0;
        fin_wen   = 1'b0;
        fin_waddr = '0;
    endtask

    task automatic do_reset();
        clear_in();
        en = 1'b0;
        trace_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start();
        en = 1'b1;
        tick();
        en = 1'b0;
        cyc = 0;
    endtask

    // Drive one channel for the coming edge; if cap, the record is expected in the FIFO.
    task automatic set_ch(input int ch, input logic [1:0] k, input logic [31:0] tg,
                          input logic [31:0] ins, input logic [31:0] ad,
                          input logic [31:0] dt, input bit cap);
        trace_rec_t e;
        ret_valid[ch]           = 1'b1;
        ret_kind[2*ch +: 2]     = k;
        ret_tag[32*ch +: 32]    = tg;
        ret_instr[32*ch +: 32]  = ins;
        ret_addr[32*ch +: 32]   = ad;
        ret_data[32*ch +: 32]   = dt;
        if (cap) begin
            e.cycle = 32'(cyc);
            e.chan  = 2'(ch);
            e.kind  = trace_kind_e'(k);
            e.tag   = tg;
            e.instr = ins;
            e.addr  = ad;
            e.data  = dt;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_rand(input int ch, input bit cap);
        logic [1:0] k;
        k = 2'($urandom_range(0, 3));
        set_ch(ch, k, $urandom, $urandom, $urandom, (k >= 2'd2) ? 32'd0 : $urandom, cap);
    endtask

    // Scoreboard: pop n records with ready held high, comparing each head in order.
    task automatic sb_drain(input int n, input int budget);
        int got;
        logic [REC_W-1:0] e;
        got = 0;
        trace_ready = 1'b1;
        for (int k = 0; k < budget && got < n; k++) begin
            if (trace_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL drain_extra: got %h expected no record", trace_rec);
                end else begin
                    e = exp_q.pop_front();
                    if (trace_rec !== e) begin
                        bad++;
                        $display("FAIL drain_rec: got %h expected %h", trace_rec, e);
                    end
                end
                got++;
            end
            tick();
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL drain_count: got %0d expected %0d", got, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({trace_valid, overflow, timeout, done} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b expected 0000", {trace_valid, overflow, timeout, done});
        end
        total++;
        if (cycle_count !== '0 || drop_count !== '0) begin
            bad++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, drop_count);
        end
        total++;
        if (dbg_state !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        // Retires and finish stores in IDLE must have no effect.
        fin_wen = 1'b1; fin_waddr = FIN;
        set_rand(0, 1'b0);
        repeat (2) tick();
        clear_in();
        total++;
        if (dbg_state !== IDLE || trace_valid !== 1'b0 || cycle_count !== '0) begin
            bad++; $display("FAIL idle_ignore: got st=%0d v=%b cc=%0d expected st=0 v=0 cc=0",
                            dbg_state, trace_valid, cycle_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        start();
        repeat (3) tick();
        set_ch(0, REG, 32'h80, 32'h0050_0093, 32'd1, 32'h5, 1'b1);
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL single_pre: got %b expected 0", trace_valid);
        end
        tick();
        clear_in();
        total++;
        if (trace_valid !== 1'b1) begin
            bad++; $display("FAIL single_valid: got %b expected 1", trace_valid);
        end
        sb_drain(1, 5);
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL single_empty: got %b expected 0", trace_valid);
        end
    endtask

    task automatic test_dual();
        do_reset();
        start();
        trace_ready = 1'b1;
        tick();
        set_rand(0, 1'b1);
        set_rand(1, 1'b1);
        tick();
        clear_in();
        sb_drain(2, 6);
    endtask

    task automatic test_overflow();
        do_reset();
        start();
        for (int p = 0; p < 8; p++) begin
            set_rand(0, 1'b1);
            set_rand(1, 1'b1);
            tick();
            clear_in();
        end
        total++;
        if (overflow !== 1'b0 || drop_count !== '0) begin
            bad++; $display("FAIL ovf_full: got ovf=%b drop=%0d expected 0/0", overflow, drop_count);
        end
        set_rand(0, 1'b0);
        set_rand(1, 1'b0);
        tick();
        clear_in();
        total++;
        if (overflow !== 1'b1 || drop_count !== 32'd2) begin
            bad++; $display("FAIL ovf_drop: got ovf=%b drop=%0d expected 1/2", overflow, drop_count);
        end
        total++;
        if (trace_rec !== exp_q[0]) begin
            bad++; $display("FAIL ovf_head_stable: got %h expected %h", trace_rec, exp_q[0]);
        end
        sb_drain(16, 40);
        total++;
        if (trace_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_after: got %b expected 0", trace_valid);
        end
    endtask

    // One free slot and two valid channels: nothing may be written.
    task automatic test_overflow_partial();
        do_reset();
        start();
        for (int p = 0; p < 7; p++) begin
            set_rand(0, 1'b1);
            set_rand(1, 1'b1);
            tick();
            clear_in();
        end
        set_rand(1, 1'b1);
        tick(); clear_in();
        set_rand(0, 1'b0);
        set_rand(1, 1'b0);
        tick(); clear_in();
        total++;
        if (drop_count !== 32'd2 || overflow !== 1'b1) begin
            bad++; $display("FAIL part_drop: got drop=%0d ovf=%b expected 2/1", drop_count, overflow);
        end
        set_rand(0, 1'b1);
        tick(); clear_in();
        set_rand(0, 1'b0);
        tick(); clear_in();
        total++;
        if (drop_count !== 32'd3) begin
            bad++; $display("FAIL part_drop_single: got %0d expected 3", drop_count);
        end
        sb_drain(16, 40);
    endtask

    task automatic test_finish_drain();
        int got;
        logic [REC_W-1:0] e;
        do_reset();
        start();
        set_rand(0, 1'b1); set_rand(1, 1'b1);
        tick(); clear_in();
        set_rand(0, 1'b1);
        tick(); clear_in();
        fin_wen = 1'b1; fin_waddr = FIN; trace_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && got < 3; k++) begin
            if (trace_valid) begin
                total++;
                e = exp_q.pop_front();
                if (trace_rec !== e) begin
                    bad++; $display("FAIL fin_rec: got %h expected %h", trace_rec, e);
                end
                got++;
            end
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL fin_done_early: got %b expected 0", done);
            end
            tick();
            // Retires and finish stores while draining must be ignored.
            clear_in();
            set_rand(0, 1'b0); set_rand(1, 1'b0);
            fin_wen = 1'b1; fin_waddr = FIN;
        end
        total++;
        if (got != 3) begin
            bad++; $display("FAIL fin_pops: got %0d expected 3", got);
        end
        total++;
        if (dbg_state !== DRAIN || trace_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL fin_last_pop: got st=%0d v=%b d=%b expected st=2 v=0 d=0",
                            dbg_state, trace_valid, done);
        end
        tick();
        total++;
        if (done !== 1'b1 || dbg_state !== DONE || timeout !== 1'b0) begin
            bad++; $display("FAIL fin_done: got d=%b st=%0d to=%b expected d=1 st=3 to=0",
                            done, dbg_state, timeout);
        end
        // Cycles 0..5 are RUN (0..2) and DRAIN (3..5).
        total++;
        if (cycle_count !== 32'd6) begin
            bad++; $display("FAIL fin_cycles: got %0d expected 6", cycle_count);
        end
        repeat (3) tick();
        clear_in();
        total++;
        if (dbg_state !== DONE || trace_valid !== 1'b0 || cycle_count !== 32'd6) begin
            bad++; $display("FAIL done_terminal: got st=%0d v=%b cc=%0d expected st=3 v=0 cc=6",
                            dbg_state, trace_valid, cycle_count);
        end
    endtask

    task automatic test_finish_capture();
        do_reset();
        start();
        repeat (2) tick();
        set_rand(1, 1'b1);
        fin_wen = 1'b1; fin_waddr = FIN;
        tick();
        clear_in();
        total++;
        if (dbg_state !== DRAIN || trace_valid !== 1'b1) begin
            bad++; $display("FAIL fincap_state: got st=%0d v=%b expected st=2 v=1", dbg_state, trace_valid);
        end
        sb_drain(1, 5);
    endtask

    task automatic test_timeout();
        do_reset();
        start();
        fin_wen = 1'b1; fin_waddr = FIN + 32'd4;
        repeat (TMO - 1) tick();
        total++;
        if (dbg_state !== RUN || timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_early: got st=%0d to=%b expected st=1 to=0", dbg_state, timeout);
        end
        tick();
        clear_in();
        total++;
        if (dbg_state !== DRAIN || timeout !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL tmo_fire: got st=%0d to=%b d=%b expected st=2 to=1 d=0",
                            dbg_state, timeout, done);
        end
        tick();
        total++;
        if (done !== 1'b1 || dbg_state !== DONE) begin
            bad++; $display("FAIL tmo_done: got d=%b st=%0d expected d=1 st=3", done, dbg_state);
        end
    endtask

    task automatic test_timeout_restart();
        do_reset();
        start();
        repeat (TMO - 2) tick();
        set_rand(0, 1'b1);
        tick();
        clear_in();
        repeat (TMO - 1) tick();
        total++;
        if (dbg_state !== RUN || timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_restart_early: got st=%0d to=%b expected st=1 to=0", dbg_state, timeout);
        end
        tick();
        total++;
        if (dbg_state !== DRAIN || timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_restart_fire: got st=%0d to=%b expected st=2 to=1", dbg_state, timeout);
        end
        sb_drain(1, 5);
    endtask

    task automatic test_finish_vs_timeout();
        do_reset();
        start();
        repeat (TMO - 1) tick();
        fin_wen = 1'b1; fin_waddr = FIN;
        tick();
        clear_in();
        total++;
        if (dbg_state !== DRAIN || timeout !== 1'b0) begin
            bad++; $display("FAIL fin_wins: got st=%0d to=%b expected st=2 to=0", dbg_state, timeout);
        end
        tick();
        total++;
        if (done !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL fin_wins_done: got d=%b to=%b expected d=1 to=0", done, timeout);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        start();
        for (int p = 0; p < 9; p++) begin
            set_rand(0, 1'b0); set_rand(1, 1'b0);
            tick(); clear_in();
        end
        fin_wen = 1'b1; fin_waddr = FIN;
        tick();
        clear_in();
        total++;
        if (dbg_state !== DRAIN || trace_valid !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL rst_setup: got st=%0d v=%b ovf=%b expected st=2 v=1 ovf=1",
                            dbg_state, trace_valid, overflow);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (trace_valid !== 1'b0 || dbg_state !== IDLE) begin
            bad++; $display("FAIL rst_async: got v=%b st=%0d expected v=0 st=0", trace_valid, dbg_state);
        end
        total++;
        if (cycle_count !== '0 || drop_count !== '0 || {overflow, timeout, done} !== 3'b0) begin
            bad++; $display("FAIL rst_async_cnt: got cc=%0d drop=%0d flags=%b expected 0/0/000",
                            cycle_count, drop_count, {overflow, timeout, done});
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        total++;
        if (dbg_state !== IDLE || trace_valid !== 1'b0) begin
            bad++; $display("FAIL rst_release: got st=%0d v=%b expected st=0 v=0", dbg_state, trace_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        en = 1'b0;
        trace_ready = 1'b0;
        clear_in();
        test_reset();
        test_single();
        test_dual();
        test_overflow();
        test_overflow_partial();
        test_finish_drain();
        test_finish_capture();
        test_timeout();
        test_timeout_restart();
        test_finish_vs_timeout();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
